// File: rtl/ext_int_pkg.sv
// Shared types and sizing helpers for the external interrupt conditioner.
package ext_int_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FILTER   = 2'd1,
        ASSERTED = 2'd2,
        HOLDOFF  = 2'd3
    } ext_int_state_e;

    // Counter must reach the larger of the two limits without wrapping.
    function automatic int cnt_width(input int filter_cycles, input int holdoff_cycles);
        int max_cycles;
        max_cycles = (filter_cycles > holdoff_cycles) ? filter_cycles : holdoff_cycles;
        return $clog2(max_cycles + 1);
    endfunction

endpackage

// File: rtl/ext_int_channel.sv
// One interrupt pin: 2-FF synchronizer, glitch filter, edge qualification,
// holdoff window and sticky overrun flag.
module ext_int_channel
    import ext_int_pkg::*;
#(
    parameter int FILTER_CYCLES  = 8,
    parameter int HOLDOFF_CYCLES = 256
) (
    input  logic clk,
    input  logic nreset,
    input  logic nint_i,
    input  logic enable_i,
    input  logic overrun_clr_i,
    output logic int_o,
    output logic level_o,
    output logic overrun_o
);

    localparam int CNT_W = cnt_width(FILTER_CYCLES, HOLDOFF_CYCLES);
    localparam logic [CNT_W-1:0] FILTER_LAST  = CNT_W'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);

    logic           s1_q;
    logic           s2_q;
    logic           s2_prev_q;
    ext_int_state_e state_q;
    logic [CNT_W-1:0] cnt_q;
    logic           int_q;
    logic           level_q;
    logic           overrun_q;

    // Synchronizer chain plus one extra stage for 1->0 transition detection.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            s2_prev_q <= 1'b1;
        end else begin
            s1_q      <= nint_i;
            s2_q      <= s1_q;
            s2_prev_q <= s2_q;
        end
    end

    // Channel FSM with registered pulse, level and overrun outputs.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= IDLE;
            cnt_q     <= CNT_ZERO;
            int_q     <= 1'b0;
            level_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            int_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    level_q <= 1'b0;
                    if (!s2_q) begin
                        state_q <= FILTER;
                        cnt_q   <= CNT_ZERO;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                FILTER: begin
                    if (s2_q) begin
                        state_q <= IDLE;
                    end else if (cnt_q == FILTER_LAST) begin
                        state_q <= ASSERTED;
                        int_q   <= enable_i;
                        level_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ASSERTED: begin
                    if (s2_q) begin
                        state_q <= HOLDOFF;
                        cnt_q   <= CNT_ZERO;
                        level_q <= 1'b0;
                    end else begin
                        level_q <= 1'b1;
                    end
                end
                HOLDOFF: begin
                    if (cnt_q == HOLDOFF_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= CNT_ZERO;
                    level_q <= 1'b0;
                end
            endcase

            // A fresh falling edge inside holdoff is dropped but remembered; set beats clear.
            if ((state_q == HOLDOFF) && s2_prev_q && !s2_q) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr_i) begin
                overrun_q <= 1'b0;
            end else begin
                overrun_q <= overrun_q;
            end
        end
    end

    assign int_o     = int_q;
    assign level_o   = level_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/ext_int_controller.sv
// Conditions the active-low external interrupt pins into single-cycle CPU
// interrupt pulses; bit i of every bus belongs to pin nint(i+1).
module ext_int_controller
    import ext_int_pkg::*;
#(
    parameter int CHANNELS       = 4,
    parameter int FILTER_CYCLES  = 8,
    parameter int HOLDOFF_CYCLES = 256
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic [CHANNELS-1:0] nint_in,
    input  logic [CHANNELS-1:0] enable,
    input  logic [CHANNELS-1:0] overrun_clr,
    output logic [CHANNELS-1:0] int_out,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] overrun
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        ext_int_channel #(
            .FILTER_CYCLES (FILTER_CYCLES),
            .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
        ) u_ch (
            .clk          (clk),
            .nreset       (nreset),
            .nint_i       (nint_in[i]),
            .enable_i     (enable[i]),
            .overrun_clr_i(overrun_clr[i]),
            .int_o        (int_out[i]),
            .level_o      (level_out[i]),
            .overrun_o    (overrun[i])
        );
    end

endmodule

// File: tb/tb_ext_int_controller.sv
// Directed bench for ext_int_controller with default parameters (filter 8, holdoff 256).
module tb_ext_int_controller;

    logic       clk = 1'b0;
    logic       nreset;
    logic [3:0] nint_in;
    logic [3:0] enable;
    logic [3:0] overrun_clr;
    logic [3:0] int_out;
    logic [3:0] level_out;
    logic [3:0] overrun;

    int checks   = 0;
    int failures = 0;
    int now      = 0;
    int e, r, f;
    logic [3:0] seen_int, seen_lvl, seen_ovr;

    always #20 clk = ~clk;

    ext_int_controller dut (
        .clk        (clk),
        .nreset     (nreset),
        .nint_in    (nint_in),
        .enable     (enable),
        .overrun_clr(overrun_clr),
        .int_out    (int_out),
        .level_out  (level_out),
        .overrun    (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // After step, 'now' is the index of the edge just passed; inputs set next hit edge now+1.
    task automatic step();
        @(posedge clk);
        #1;
        now++;
        seen_int = seen_int | int_out;
        seen_lvl = seen_lvl | level_out;
        seen_ovr = seen_ovr | overrun;
    endtask

    task automatic run_to(input int target);
        while (now < target) step();
    endtask

    task automatic clear_seen();
        seen_int = 4'h0;
        seen_lvl = 4'h0;
        seen_ovr = 4'h0;
    endtask

    initial begin
        nreset      = 1'b0;
        nint_in     = 4'hF;
        enable      = 4'hF;
        overrun_clr = 4'h0;
        clear_seen();

        // Reset
        #5;
        chk("reset_outputs", {20'h0, int_out, level_out, overrun}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_held", {20'h0, int_out, level_out, overrun}, 32'h0);
        nreset = 1'b1;
        clear_seen();
        run_to(now + 50);
        chk("post_reset_quiet", {24'h0, seen_int, seen_lvl}, 32'h0);

        // Clean edge on ch0
        clear_seen();
        nint_in[0] = 1'b0;
        e = now + 1;
        run_to(e + 9);
        chk("clean_no_early", {28'h0, seen_int}, 32'h0);
        step();
        chk("clean_pulse", {28'h0, int_out}, 32'h1);
        chk("clean_level_rise", {28'h0, level_out}, 32'h1);
        step();
        chk("clean_single", {28'h0, int_out}, 32'h0);
        chk("clean_level_hold", {31'h0, level_out[0]}, 32'h1);
        run_to(e + 19);
        nint_in[0] = 1'b1;
        r = now + 1;
        run_to(r + 1);
        chk("clean_level_late", {31'h0, level_out[0]}, 32'h1);
        step();
        chk("clean_level_fall", {31'h0, level_out[0]}, 32'h0);
        chk("clean_other_quiet", {28'h0, seen_int}, 32'h1);

        // Glitch rejection and filter boundary on ch1
        clear_seen();
        nint_in[1] = 1'b0;
        run_to(now + 5);
        nint_in[1] = 1'b1;
        run_to(now + 20);
        chk("glitch_rejected", {30'h0, seen_int[1], seen_lvl[1]}, 32'h0);
        nint_in[1] = 1'b0;
        e = now + 1;
        run_to(e + 7);
        nint_in[1] = 1'b1;
        run_to(e + 20);
        chk("filter_8_rejected", {30'h0, seen_int[1], seen_lvl[1]}, 32'h0);
        nint_in[1] = 1'b0;
        e = now + 1;
        run_to(e + 8);
        nint_in[1] = 1'b1;
        run_to(e + 9);
        chk("filter_9_early", {31'h0, int_out[1]}, 32'h0);
        step();
        chk("filter_9_pulse", {31'h0, int_out[1]}, 32'h1);

        // Holdoff and overrun on ch2
        nint_in[2] = 1'b0;
        e = now + 1;
        run_to(e + 10);
        chk("ho_first_pulse", {31'h0, int_out[2]}, 32'h1);
        run_to(e + 19);
        nint_in[2] = 1'b1;
        r = now + 1;
        run_to(r + 49);
        nint_in[2] = 1'b0;
        f = r + 50;
        clear_seen();
        run_to(f + 1);
        chk("ovr_latency_early", {31'h0, overrun[2]}, 32'h0);
        step();
        chk("ovr_set", {31'h0, overrun[2]}, 32'h1);
        run_to(r + 266);
        chk("ho_no_pulse", {31'h0, seen_int[2]}, 32'h0);
        step();
        chk("ho_rearm_pulse", {31'h0, int_out[2]}, 32'h1);
        overrun_clr[2] = 1'b1;
        step();
        overrun_clr[2] = 1'b0;
        chk("ovr_clear", {31'h0, overrun[2]}, 32'h0);
        nint_in[2] = 1'b1;
        r = now + 1;
        run_to(r + 9);
        nint_in[2] = 1'b0;
        f = r + 10;
        run_to(f + 1);
        overrun_clr[2] = 1'b1;
        step();
        overrun_clr[2] = 1'b0;
        chk("ovr_set_wins", {31'h0, overrun[2]}, 32'h1);
        nint_in[2] = 1'b1;
        run_to(now + 300);

        // Masked channel 3
        enable = 4'b0111;
        clear_seen();
        nint_in[3] = 1'b0;
        e = now + 1;
        run_to(e + 10);
        chk("mask_level_rise", {31'h0, level_out[3]}, 32'h1);
        nint_in[3] = 1'b1;
        r = now + 1;
        run_to(r + 2);
        chk("mask_level_fall", {31'h0, level_out[3]}, 32'h0);
        chk("mask_no_pulse", {31'h0, seen_int[3]}, 32'h0);
        enable = 4'hF;
        run_to(now + 300);

        // All four channels on the same edge
        nint_in = 4'h0;
        e = now + 1;
        run_to(e + 9);
        chk("all_no_early", {28'h0, int_out}, 32'h0);
        step();
        chk("all_pulse", {28'h0, int_out}, 32'hF);
        chk("all_level", {28'h0, level_out}, 32'hF);
        nint_in = 4'hF;
        run_to(now + 300);

        // Async reset with ch0 in FILTER and ch1 in HOLDOFF
        nint_in[1] = 1'b0;
        e = now + 1;
        run_to(e + 10);
        nint_in[1] = 1'b1;
        run_to(e + 14);
        nint_in[1:0] = 2'b00;
        run_to(e + 19);
        chk("pre_rst_overrun", {31'h0, overrun[1]}, 32'h1);
        #5;
        nreset = 1'b0;
        #1;
        chk("async_rst_immediate", {20'h0, int_out, level_out, overrun}, 32'h0);
        nint_in = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        nreset = 1'b1;
        clear_seen();
        run_to(now + 40);
        chk("post_rst_quiet", {20'h0, seen_int, seen_lvl, seen_ovr}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
